read_data_router: RTL and testbench
===================================

READ_DATA_ROUTER -- requirements
Module: read_data_router

Interface
REQ-001 Parameters SHALL be: M, default 2, number of masters; S, default 2, number of slaves; NUM_OUTSTANDING_TRANS, default 2, outstanding IDs per master; DATA_WIDTH, default 32, R data width.
REQ-002 Derived widths SHALL be: MW = $clog2(M); TW = $clog2(NUM_OUTSTANDING_TRANS); IDW = MW+TW. A slave RID is {master_id[MW], trans_id[TW]} with the master field in the MSBs.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 s_rvalid  input  S  per-slave R valid.
REQ-006 s_rready  output  S  per-slave R ready.
REQ-007 s_rdata  input  S*DATA_WIDTH  per-slave R data.
REQ-008 s_rresp  input  S*2  per-slave R response.
REQ-009 s_rlast  input  S  per-slave last beat.
REQ-010 s_rid  input  S*IDW  per-slave RID.
REQ-011 R_request_f  output  S  request to the read arbiter.
REQ-012 R_id_f  output  S*IDW  RID forwarded to the read arbiter.
REQ-013 R_last_f  output  S  last-beat-accepted indication to the arbiter.
REQ-014 R_grant_f  input  S  data-phase grant from the arbiter.
REQ-015 R_sel_f  input  S*MW  destination master for each slave, from the arbiter.
REQ-016 m_rvalid  output  M  per-master R valid.
REQ-017 m_rready  input  M  per-master R ready.
REQ-018 m_rdata, m_rresp, m_rlast  outputs  M*DATA_WIDTH, M*2, M  per-master R payload.
REQ-019 m_rid  output  M*TW  master-local transaction ID, with the master field stripped.

Function
REQ-020 R_request_f[s] SHALL equal s_rvalid[s], and R_id_f[s] SHALL equal s_rid[s], combinationally.
REQ-021 Active slave selection: the active slave SHALL be the lowest index s with R_grant_f[s]=1. If no grant bit is set, no slave is active.
REQ-022 When more than one grant bit is set, every non-active slave SHALL see s_rready=0.
REQ-023 Destination: the active slave s SHALL target master d = R_sel_f[s].
REQ-024 s_rready[s] SHALL be 1 only when s is active and slice d can accept, i.e. (!full[d] || m_rready[d]).
REQ-025 Each master SHALL have a one-entry output register slice holding data, resp, last and trans_id, plus a full flag.
REQ-026 Slice load: on s_rvalid&s_rready, the slice SHALL load the beat and set full on the next edge. Latency from slave to master is 1 cycle.
REQ-027 Slice pop: on m_rvalid&m_rready with no load in the same cycle, full SHALL clear.
REQ-028 A simultaneous pop and load SHALL replace the contents and keep full=1, giving 1 beat/cycle sustained throughput.
REQ-029 m_rvalid[d] SHALL equal full[d]. Slice outputs SHALL hold stable while m_rvalid=1 and m_rready=0.
REQ-030 R_last_f[s] SHALL be asserted combinationally for exactly the cycle in which s_rvalid[s]&s_rready[s]&s_rlast[s] is true.
REQ-031 Grant removal mid-burst: if a grant drops mid-burst, s_rready SHALL drop in the same cycle. A beat already in a slice SHALL still be delivered, and no beat SHALL be lost or duplicated.
REQ-032 Grant without valid: a grant with s_rvalid=0 SHALL cause no slice change.
REQ-033 Idle slices: slices not targeted SHALL be unaffected by any other slave's traffic.

Reset
REQ-034 While clr=0, all full flags and m_rvalid SHALL be 0, and slice payload registers SHALL be 0.
REQ-035 During reset, s_rready SHALL be 0 regardless of R_grant_f.
REQ-036 Reset asserted mid-burst SHALL discard buffered beats. After release the block SHALL resume with empty slices within 1 cycle.

Structure
REQ-037 The shared interconnect package SHALL hold the width helper constants (MW, TW, IDW) and the RRESP encodings OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
REQ-038 Sub-module r_slice (one-entry register slice with load/pop/full) SHALL be instantiated M times in a generate loop.
REQ-039 The crossbar select logic SHALL stay in read_data_router.

Verification
REQ-040 Single beat: slave 1 s_rvalid=1, s_rid={1,1}, s_rdata=0xA5A5A5A5, s_rlast=1, grant[1]=1, sel[1]=1, m_rready[1]=1 -> R_last_f[1] pulses 1 cycle; next cycle m_rvalid[1]=1, m_rdata=0xA5A5A5A5, m_rid=1.
REQ-041 Full-rate burst: 4-beat burst slave 0 -> master 0 with data 1..4 and m_rready held 1 -> m_rvalid continuous 4 cycles carrying 1,2,3,4; m_rlast only on beat 4.
REQ-042 Backpressure: in the same burst, m_rready[0]=0 for 3 cycles after beat 2 -> s_rready[0]=0 during the stall; output stays 2; afterwards 3,4 delivered with no loss or duplicate.
REQ-043 Double grant: grant=2'b11 with both slaves valid -> only s_rready[0]=1; slave 1 stalls with no data on any master.
REQ-044 Reset mid-burst: clr=0 after beat 2 of 4 -> m_rvalid=0 and s_rready=0 immediately; after release, a new burst routes correctly.
REQ-045 Request mirroring: s_rvalid[1]=1 with grant=0 -> R_request_f[1]=1, R_id_f[1]=s_rid[1], s_rready[1]=0.

Source files
------------

// File: rtl/read_data_router_pkg.sv
// read_data_router_pkg: shared R-channel interconnect constants.
// Default widths for the router and the RRESP encodings.
package read_data_router_pkg;

  localparam int unsigned DEF_M   = 2;
  localparam int unsigned DEF_S   = 2;
  localparam int unsigned DEF_NOT = 2;

  localparam int unsigned MW  = $clog2(DEF_M);
  localparam int unsigned TW  = $clog2(DEF_NOT);
  localparam int unsigned IDW = MW + TW;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_EXOKAY = 2'b01;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  function automatic int unsigned id_w(
    input int unsigned m,
    input int unsigned n
  );
    return $clog2(m) + $clog2(n);
  endfunction

endpackage

// File: rtl/read_data_router_r_slice.sv
// r_slice: one-entry R register slice (load/pop/full).
// Ports: clk, clr, load_i/pop_i, beat in, full_o + beat out.
module r_slice #(
  parameter int DW = 32,
  parameter int TW = 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  input  logic [1:0]    resp_i,
  input  logic          last_i,
  input  logic [TW-1:0] tid_i,
  output logic          full_o,
  output logic [DW-1:0] data_o,
  output logic [1:0]    resp_o,
  output logic          last_o,
  output logic [TW-1:0] tid_o
);

  logic          full_q, full_d;
  logic [DW-1:0] data_q, data_d;
  logic [1:0]    resp_q, resp_d;
  logic          last_q, last_d;
  logic [TW-1:0] tid_q, tid_d;

  // Load wins over pop: a same-cycle pop+load replaces the beat.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    resp_d = resp_q;
    last_d = last_q;
    tid_d  = tid_q;
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
      resp_d = resp_i;
      last_d = last_i;
      tid_d  = tid_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      full_q <= 1'b0;
      data_q <= '0;
      resp_q <= '0;
      last_q <= 1'b0;
      tid_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      resp_q <= resp_d;
      last_q <= last_d;
      tid_q  <= tid_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;
  assign resp_o = resp_q;
  assign last_o = last_q;
  assign tid_o  = tid_q;

endmodule

// File: rtl/read_data_router.sv
// read_data_router: routes slave R beats to masters via arbiter grants.
// Ports: s_r* slave side, R_*_f arbiter side, m_r* master side.
module read_data_router
  import read_data_router_pkg::*;
#(
  parameter int M                     = 2,
  parameter int S                     = 2,
  parameter int NUM_OUTSTANDING_TRANS = 2,
  parameter int DATA_WIDTH            = 32
) (
  input  logic                                   clk,
  input  logic                                   clr,
  input  logic [S-1:0]                           s_rvalid,
  output logic [S-1:0]                           s_rready,
  input  logic [S*DATA_WIDTH-1:0]                s_rdata,
  input  logic [S*2-1:0]                         s_rresp,
  input  logic [S-1:0]                           s_rlast,
  input  logic [S*($clog2(M)+$clog2(NUM_OUTSTANDING_TRANS))-1:0] s_rid,
  output logic [S-1:0]                           R_request_f,
  output logic [S*($clog2(M)+$clog2(NUM_OUTSTANDING_TRANS))-1:0] R_id_f,
  output logic [S-1:0]                           R_last_f,
  input  logic [S-1:0]                           R_grant_f,
  input  logic [S*$clog2(M)-1:0]                 R_sel_f,
  output logic [M-1:0]                           m_rvalid,
  input  logic [M-1:0]                           m_rready,
  output logic [M*DATA_WIDTH-1:0]                m_rdata,
  output logic [M*2-1:0]                         m_rresp,
  output logic [M-1:0]                           m_rlast,
  output logic [M*$clog2(NUM_OUTSTANDING_TRANS)-1:0] m_rid
);

  localparam int LMW  = $clog2(M);
  localparam int LTW  = $clog2(NUM_OUTSTANDING_TRANS);
  localparam int LIDW = LMW + LTW;
  localparam int SW   = (S > 1) ? $clog2(S) : 1;

  logic                  act_valid;
  logic [SW-1:0]         act_idx;
  logic [LMW-1:0]        dest;
  logic                  can_accept;
  logic                  fire;
  logic [M-1:0]          full;
  logic [M-1:0]          load;
  logic [M-1:0]          pop;
  logic [DATA_WIDTH-1:0] in_data;
  logic [1:0]            in_resp;
  logic                  in_last;
  logic [LTW-1:0]        in_tid;

  assign R_request_f = s_rvalid;
  assign R_id_f      = s_rid;

  // Lowest granted index wins; scan downward so it is written last.
  always_comb begin
    act_valid = 1'b0;
    act_idx   = '0;
    for (int s = S - 1; s >= 0; s--) begin
      if (R_grant_f[s]) begin
        act_valid = 1'b1;
        act_idx   = SW'(s);
      end
    end
  end

  assign dest       = R_sel_f[act_idx*LMW +: LMW];
  assign can_accept = !full[dest] || m_rready[dest];

  always_comb begin
    s_rready = '0;
    if (clr && act_valid && can_accept) begin
      s_rready[act_idx] = 1'b1;
    end
  end

  assign fire     = act_valid && s_rvalid[act_idx] && s_rready[act_idx];
  assign R_last_f = s_rvalid & s_rready & s_rlast;

  assign in_data = s_rdata[act_idx*DATA_WIDTH +: DATA_WIDTH];
  assign in_resp = s_rresp[act_idx*2 +: 2];
  assign in_last = s_rlast[act_idx];
  // Low bits of the RID are the master-local transaction ID.
  assign in_tid  = s_rid[act_idx*LIDW +: LTW];

  assign m_rvalid = full;

  for (genvar m = 0; m < M; m++) begin : g_slice
    assign load[m] = fire && (dest == LMW'(m));
    assign pop[m]  = full[m] && m_rready[m];

    r_slice #(
      .DW (DATA_WIDTH),
      .TW (LTW)
    ) u_slice (
      .clk    (clk),
      .clr    (clr),
      .load_i (load[m]),
      .pop_i  (pop[m]),
      .data_i (in_data),
      .resp_i (in_resp),
      .last_i (in_last),
      .tid_i  (in_tid),
      .full_o (full[m]),
      .data_o (m_rdata[m*DATA_WIDTH +: DATA_WIDTH]),
      .resp_o (m_rresp[m*2 +: 2]),
      .last_o (m_rlast[m]),
      .tid_o  (m_rid[m*LTW +: LTW])
    );
  end

endmodule

// File: tb/tb_read_data_router.sv
// tb_read_data_router: directed and randomized checks of the R router.
// Reference model keeps one bounded queue per master.
module tb_read_data_router;

  localparam int M   = 2;
  localparam int S   = 2;
  localparam int NOT = 2;
  localparam int DW  = 32;
  localparam int MW  = $clog2(M);
  localparam int TW  = $clog2(NOT);
  localparam int IDW = MW + TW;
  localparam int BW  = DW + 2 + 1 + TW;

  typedef logic [BW-1:0] beat_t;

  logic              clk;
  logic              clr;
  logic [S-1:0]      s_rvalid;
  logic [S-1:0]      s_rready;
  logic [S*DW-1:0]   s_rdata;
  logic [S*2-1:0]    s_rresp;
  logic [S-1:0]      s_rlast;
  logic [S*IDW-1:0]  s_rid;
  logic [S-1:0]      R_request_f;
  logic [S*IDW-1:0]  R_id_f;
  logic [S-1:0]      R_last_f;
  logic [S-1:0]      R_grant_f;
  logic [S*MW-1:0]   R_sel_f;
  logic [M-1:0]      m_rvalid;
  logic [M-1:0]      m_rready;
  logic [M*DW-1:0]   m_rdata;
  logic [M*2-1:0]    m_rresp;
  logic [M-1:0]      m_rlast;
  logic [M*TW-1:0]   m_rid;

  int checks = 0;
  int errors = 0;

  read_data_router #(
    .M                     (M),
    .S                     (S),
    .NUM_OUTSTANDING_TRANS (NOT),
    .DATA_WIDTH            (DW)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .s_rvalid    (s_rvalid),
    .s_rready    (s_rready),
    .s_rdata     (s_rdata),
    .s_rresp     (s_rresp),
    .s_rlast     (s_rlast),
    .s_rid       (s_rid),
    .R_request_f (R_request_f),
    .R_id_f      (R_id_f),
    .R_last_f    (R_last_f),
    .R_grant_f   (R_grant_f),
    .R_sel_f     (R_sel_f),
    .m_rvalid    (m_rvalid),
    .m_rready    (m_rready),
    .m_rdata     (m_rdata),
    .m_rresp     (m_rresp),
    .m_rlast     (m_rlast),
    .m_rid       (m_rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    s_rvalid  = '0;
    s_rdata   = '0;
    s_rresp   = '0;
    s_rlast   = '0;
    s_rid     = '0;
    R_grant_f = '0;
    R_sel_f   = '0;
    m_rready  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive_idle();
    clr       = 1'b0;
    s_rvalid  = 2'b11;
    R_grant_f = 2'b11;
    m_rready  = 2'b11;
    #1;
    checks++;
    if (s_rready !== 2'b00) begin
      errors++;
      $display("FAIL reset_rready got=%b exp=00", s_rready);
    end
    checks++;
    if (m_rvalid !== 2'b00) begin
      errors++;
      $display("FAIL reset_mvalid got=%b exp=00", m_rvalid);
    end
    checks++;
    if ({m_rdata, m_rresp, m_rlast, m_rid} !== '0) begin
      errors++;
      $display("FAIL reset_payload got=%h exp=0",
               {m_rdata, m_rresp, m_rlast, m_rid});
    end
    @(negedge clk);
    drive_idle();
    clr = 1'b1;
  endtask

  task automatic test_request_mirror();
    logic [IDW-1:0] rid;
    do_reset();
    rid = IDW'($urandom);
    s_rvalid = 2'b10;
    s_rid[IDW +: IDW] = rid;
    R_grant_f = 2'b00;
    m_rready = 2'b11;
    #1;
    checks++;
    if (R_request_f !== 2'b10) begin
      errors++;
      $display("FAIL mirror_req got=%b exp=10", R_request_f);
    end
    checks++;
    if (R_id_f[IDW +: IDW] !== rid) begin
      errors++;
      $display("FAIL mirror_id got=%h exp=%h", R_id_f[IDW +: IDW], rid);
    end
    checks++;
    if (s_rready !== 2'b00) begin
      errors++;
      $display("FAIL mirror_rready got=%b exp=00", s_rready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (m_rvalid !== 2'b00) begin
      errors++;
      $display("FAIL mirror_nogrant_mvalid got=%b exp=00", m_rvalid);
    end
    drive_idle();
  endtask

  task automatic test_single_beat();
    do_reset();
    s_rvalid = 2'b10;
    s_rid[IDW +: IDW] = {1'b1, 1'b1};
    s_rdata[DW +: DW] = 32'hA5A5A5A5;
    s_rlast = 2'b10;
    R_grant_f = 2'b10;
    R_sel_f[MW +: MW] = 1'b1;
    m_rready = 2'b10;
    #1;
    checks++;
    if (R_last_f !== 2'b10 || s_rready !== 2'b10) begin
      errors++;
      $display("FAIL single_accept last=%b rdy=%b exp=10/10",
               R_last_f, s_rready);
    end
    @(negedge clk);
    s_rvalid = 2'b00;
    #1;
    checks++;
    if (R_last_f !== 2'b00) begin
      errors++;
      $display("FAIL single_last_pulse got=%b exp=00", R_last_f);
    end
    checks++;
    if (m_rvalid !== 2'b10 || m_rdata[DW +: DW] !== 32'hA5A5A5A5 ||
        m_rid[TW +: TW] !== 1'b1 || m_rlast[1] !== 1'b1) begin
      errors++;
      $display("FAIL single_out v=%b d=%h id=%b l=%b exp=10/a5a5a5a5/1/1",
               m_rvalid, m_rdata[DW +: DW], m_rid[TW +: TW], m_rlast[1]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (m_rvalid !== 2'b00) begin
      errors++;
      $display("FAIL single_pop got=%b exp=00", m_rvalid);
    end
    drive_idle();
  endtask

  task automatic test_burst();
    do_reset();
    R_grant_f = 2'b01;
    R_sel_f   = '0;
    m_rready  = 2'b01;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      s_rvalid[0] = (k < 4);
      s_rdata[DW-1:0] = DW'(k + 1);
      s_rlast[0] = (k == 3);
      #1;
      if (k < 4) begin
        checks++;
        if (s_rready[0] !== 1'b1 || R_last_f[0] !== (k == 3)) begin
          errors++;
          $display("FAIL burst_in k=%0d rdy=%b last=%b", k,
                   s_rready[0], R_last_f[0]);
        end
      end
      if (k > 0) begin
        checks++;
        if (m_rvalid[0] !== 1'b1 || m_rdata[DW-1:0] !== DW'(k) ||
            m_rlast[0] !== (k == 4)) begin
          errors++;
          $display("FAIL burst_out k=%0d v=%b d=%0d l=%b exp=1/%0d/%b",
                   k, m_rvalid[0], m_rdata[DW-1:0], m_rlast[0], k, k == 4);
        end
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (m_rvalid !== 2'b00) begin
      errors++;
      $display("FAIL burst_drain got=%b exp=00", m_rvalid);
    end
    drive_idle();
  endtask

  task automatic test_backpressure();
    int unsigned got[$];
    int i = 0;
    int stall = 0;
    bit seen2 = 0;
    do_reset();
    R_grant_f = 2'b01;
    R_sel_f   = '0;
    for (int c = 0; c < 30 && got.size() < 4; c++) begin
      @(negedge clk);
      if (!seen2 && m_rvalid[0] && m_rdata[DW-1:0] == 2) begin
        seen2 = 1;
        stall = 3;
      end
      m_rready[0] = (stall == 0);
      s_rvalid[0] = (i < 4);
      s_rdata[DW-1:0] = DW'(i + 1);
      s_rlast[0] = (i == 3);
      #1;
      if (stall > 0) begin
        checks++;
        if (s_rready[0] !== 1'b0 || m_rvalid[0] !== 1'b1 ||
            m_rdata[DW-1:0] !== 2) begin
          errors++;
          $display("FAIL bp_stall rdy=%b v=%b d=%0d exp=0/1/2",
                   s_rready[0], m_rvalid[0], m_rdata[DW-1:0]);
        end
        stall--;
      end
      if (m_rvalid[0] && m_rready[0]) got.push_back(m_rdata[DW-1:0]);
      if (s_rvalid[0] && s_rready[0]) i++;
    end
    checks++;
    if (!seen2) begin
      errors++;
      $display("FAIL bp_seen2 got=0 exp=1");
    end
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL bp_count got=%0d exp=4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] != k + 1) begin
          errors++;
          $display("FAIL bp_order k=%0d got=%0d exp=%0d", k, got[k], k + 1);
        end
      end
    end
    drive_idle();
  endtask

  task automatic test_double_grant();
    do_reset();
    R_grant_f = 2'b11;
    s_rvalid  = 2'b11;
    s_rdata   = {32'h2222_2222, 32'h1111_1111};
    R_sel_f   = 2'b10;
    m_rready  = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (s_rready !== 2'b01) begin
        errors++;
        $display("FAIL dgrant_rready c=%0d got=%b exp=01", c, s_rready);
      end
      checks++;
      if (m_rvalid[1] !== 1'b0) begin
        errors++;
        $display("FAIL dgrant_m1 c=%0d got=%b exp=0", c, m_rvalid[1]);
      end
    end
    checks++;
    if (m_rvalid[0] !== 1'b1 || m_rdata[DW-1:0] !== 32'h1111_1111) begin
      errors++;
      $display("FAIL dgrant_m0 v=%b d=%h exp=1/11111111",
               m_rvalid[0], m_rdata[DW-1:0]);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    R_grant_f = 2'b01;
    R_sel_f   = '0;
    m_rready  = 2'b00;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      s_rvalid[0] = 1'b1;
      s_rdata[DW-1:0] = DW'(k + 1);
      m_rready[0] = 1'b1;
    end
    @(negedge clk);
    s_rdata[DW-1:0] = 3;
    m_rready = 2'b00;
    clr = 1'b0;
    #1;
    checks++;
    if (m_rvalid !== 2'b00 || s_rready !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_clear v=%b rdy=%b exp=00/00", m_rvalid, s_rready);
    end
    @(negedge clk);
    clr = 1'b1;
    s_rvalid = 2'b00;
    #1;
    checks++;
    if (m_rvalid !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_empty got=%b exp=00", m_rvalid);
    end
    @(negedge clk);
    s_rvalid[0] = 1'b1;
    s_rdata[DW-1:0] = 32'h55;
    s_rid[IDW-1:0] = {1'b1, 1'b0};
    R_sel_f[MW-1:0] = 1'b1;
    m_rready = 2'b10;
    @(negedge clk);
    s_rvalid = 2'b00;
    #1;
    checks++;
    if (m_rvalid !== 2'b10 || m_rdata[DW +: DW] !== 32'h55 ||
        m_rid[TW +: TW] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_resume v=%b d=%h id=%b exp=10/55/0",
               m_rvalid, m_rdata[DW +: DW], m_rid[TW +: TW]);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_random();
    beat_t q[M][$];
    logic [S-1:0] exp_rdy;
    beat_t obs;
    int act;
    int d;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      s_rvalid  = S'($urandom);
      R_grant_f = ($urandom_range(0, 3) == 0) ? '0 : S'($urandom);
      R_sel_f   = (S*MW)'($urandom);
      s_rdata   = {$urandom, $urandom};
      s_rresp   = (S*2)'($urandom);
      s_rlast   = S'($urandom);
      s_rid     = (S*IDW)'($urandom);
      m_rready  = M'($urandom);
      #1;
      act = -1;
      d = 0;
      for (int s = S - 1; s >= 0; s--) if (R_grant_f[s]) act = s;
      exp_rdy = '0;
      if (act >= 0) begin
        d = int'(R_sel_f[act*MW +: MW]);
        if (q[d].size() == 0 || m_rready[d]) exp_rdy[act] = 1'b1;
      end
      checks++;
      if (s_rready !== exp_rdy) begin
        errors++;
        $display("FAIL rnd_rready c=%0d got=%b exp=%b", c, s_rready, exp_rdy);
      end
      checks++;
      if (R_last_f !== (s_rvalid & exp_rdy & s_rlast)) begin
        errors++;
        $display("FAIL rnd_last c=%0d got=%b exp=%b", c, R_last_f,
                 s_rvalid & exp_rdy & s_rlast);
      end
      checks++;
      if (R_request_f !== s_rvalid || R_id_f !== s_rid) begin
        errors++;
        $display("FAIL rnd_mirror c=%0d req=%b id=%h", c, R_request_f, R_id_f);
      end
      for (int m = 0; m < M; m++) begin
        checks++;
        if (m_rvalid[m] !== (q[m].size() != 0)) begin
          errors++;
          $display("FAIL rnd_mvalid c=%0d m=%0d got=%b exp=%b", c, m,
                   m_rvalid[m], q[m].size() != 0);
        end else if (q[m].size() != 0) begin
          obs = {m_rdata[m*DW +: DW], m_rresp[m*2 +: 2], m_rlast[m],
                 m_rid[m*TW +: TW]};
          checks++;
          if (obs !== q[m][0]) begin
            errors++;
            $display("FAIL rnd_beat c=%0d m=%0d got=%h exp=%h", c, m,
                     obs, q[m][0]);
          end
        end
      end
      for (int m = 0; m < M; m++) begin
        if (q[m].size() != 0 && m_rready[m]) void'(q[m].pop_front());
      end
      if (act >= 0 && s_rvalid[act] && exp_rdy[act]) begin
        q[d].push_back({s_rdata[act*DW +: DW], s_rresp[act*2 +: 2],
                        s_rlast[act], s_rid[act*IDW +: TW]});
      end
    end
    drive_idle();
  endtask

  initial begin
    clr = 1'b0;
    drive_idle();
    test_reset();
    test_request_mirror();
    test_single_beat();
    test_burst();
    test_backpressure();
    test_double_grant();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
